// File: rtl/ddot_feeder.sv
// ddot_feeder: packs a serial (x, y) element stream into zero-padded 4-lane
// groups and issues each group as a one-cycle strobe. Consecutive strobes are
// kept at least MIN_GAP cycles apart.
module ddot_feeder #(
  parameter int unsigned W       = 32,
  parameter int unsigned MIN_GAP = 1,
  parameter int unsigned CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_x,
  input  logic [W-1:0]  in_y,
  input  logic          in_last,
  output logic          ready,
  output logic [W-1:0]  x0,
  output logic [W-1:0]  x1,
  output logic [W-1:0]  x2,
  output logic [W-1:0]  x3,
  output logic [W-1:0]  y0,
  output logic [W-1:0]  y1,
  output logic [W-1:0]  y2,
  output logic [W-1:0]  y3,
  output logic          last,
  output logic [CW-1:0] grp_idx
);

  // The gap counter only has to hold MIN_GAP-1.
  localparam int unsigned GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  logic [W-1:0]  lane_x [4];
  logic [W-1:0]  lane_y [4];
  logic [1:0]    idx;
  logic          pending;
  logic          pend_last;
  logic [GW-1:0] gap_cnt;
  logic [CW-1:0] grp_cnt;

  logic          fire;
  logic          accept;
  logic          complete;

  // Handshake and issue decisions; a beat can land on the same cycle a group leaves.
  always_comb begin
    fire     = pending & (gap_cnt == '0);
    in_ready = ~pending | fire;
    accept   = in_valid & in_ready;
    complete = accept & ((idx == 2'd3) | in_last);
  end

  // Collect lanes: write the current lane, zero the unused tail on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      for (int i = 0; i < 4; i++) begin
        lane_x[i] <= '0;
        lane_y[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < 4; i++) begin
        if (2'(i) == idx) begin
          lane_x[i] <= in_x;
          lane_y[i] <= in_y;
        end else if (complete && (2'(i) > idx)) begin
          lane_x[i] <= '0;
          lane_y[i] <= '0;
        end
      end
      idx <= complete ? 2'd0 : idx + 2'd1;
    end
  end

  // Pending flag, issue gap timer and per-vector group counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= 1'b0;
      pend_last <= 1'b0;
      gap_cnt   <= '0;
      grp_cnt   <= '0;
    end else begin
      pending <= complete | (pending & ~fire);
      if (complete) begin
        pend_last <= in_last;
      end
      if (fire) begin
        gap_cnt <= GW'(MIN_GAP - 1);
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
      if (fire) begin
        grp_cnt <= pend_last ? '0 : grp_cnt + 1'b1;
      end
    end
  end

  // Issue registers: snapshot the collect lanes on fire, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready   <= 1'b0;
      last    <= 1'b0;
      grp_idx <= '0;
      x0 <= '0; x1 <= '0; x2 <= '0; x3 <= '0;
      y0 <= '0; y1 <= '0; y2 <= '0; y3 <= '0;
    end else begin
      ready <= fire;
      if (fire) begin
        x0 <= lane_x[0]; x1 <= lane_x[1]; x2 <= lane_x[2]; x3 <= lane_x[3];
        y0 <= lane_y[0]; y1 <= lane_y[1]; y2 <= lane_y[2]; y3 <= lane_y[3];
        last    <= pend_last;
        grp_idx <= grp_cnt;
      end
    end
  end

endmodule

// File: tb/tb_ddot_feeder.sv
// Testbench for ddot_feeder: two instances (MIN_GAP=1 and MIN_GAP=8) fed by
// directed and random vectors, checked against a grouping model.
module tb_ddot_feeder;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 16;

  typedef struct {
    int              cyc;
    logic [4*W-1:0]  x;
    logic [4*W-1:0]  y;
    logic            last;
    logic [CW-1:0]   gi;
  } grp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_x, in_y;
  logic          in_last;
  logic          v1, v8, ir1, ir8, r1, r8, l1, l8;
  logic [W-1:0]  ox1 [4];
  logic [W-1:0]  oy1 [4];
  logic [W-1:0]  ox8 [4];
  logic [W-1:0]  oy8 [4];
  logic [CW-1:0] g1, g8;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  grp_t cap1[$];
  grp_t cap8[$];
  grp_t exp_q[$];
  logic [W-1:0] vx[$];
  logic [W-1:0] vy[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ddot_feeder #(.W(W), .MIN_GAP(1), .CW(CW)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1),
    .in_x(in_x), .in_y(in_y), .in_last(in_last), .ready(r1),
    .x0(ox1[0]), .x1(ox1[1]), .x2(ox1[2]), .x3(ox1[3]),
    .y0(oy1[0]), .y1(oy1[1]), .y2(oy1[2]), .y3(oy1[3]),
    .last(l1), .grp_idx(g1)
  );

  ddot_feeder #(.W(W), .MIN_GAP(8), .CW(CW)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8),
    .in_x(in_x), .in_y(in_y), .in_last(in_last), .ready(r8),
    .x0(ox8[0]), .x1(ox8[1]), .x2(ox8[2]), .x3(ox8[3]),
    .y0(oy8[0]), .y1(oy8[1]), .y2(oy8[2]), .y3(oy8[3]),
    .last(l8), .grp_idx(g8)
  );

  // Record every issue strobe with its cycle number.
  always @(negedge clk) begin
    grp_t p;
    if (r1 === 1'b1) begin
      p.cyc = cyc; p.x = {ox1[3], ox1[2], ox1[1], ox1[0]};
      p.y = {oy1[3], oy1[2], oy1[1], oy1[0]}; p.last = l1; p.gi = g1;
      cap1.push_back(p);
    end
    if (r8 === 1'b1) begin
      p.cyc = cyc; p.x = {ox8[3], ox8[2], ox8[1], ox8[0]};
      p.y = {oy8[3], oy8[2], oy8[1], oy8[0]}; p.last = l8; p.gi = g8;
      cap8.push_back(p);
    end
  end

  // Turn the accepted beats of one finished vector into its expected groups.
  task automatic model_vector();
    int n, ng;
    grp_t e;
    n  = vx.size();
    ng = (n + 3) / 4;
    for (int g = 0; g < ng; g++) begin
      e.cyc = 0; e.x = '0; e.y = '0;
      for (int l = 0; l < 4; l++) begin
        if (4 * g + l < n) begin
          e.x[l*W +: W] = vx[4*g+l];
          e.y[l*W +: W] = vy[4*g+l];
        end
      end
      e.last = (g == ng - 1);
      e.gi   = CW'(g);
      exp_q.push_back(e);
    end
    vx.delete();
    vy.delete();
  endtask

  // Present one beat at a negedge and hold it until accepted (bounded).
  task automatic send(input bit s8, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic l, output int acc, output int waited);
    in_x = x; in_y = y; in_last = l;
    if (s8) v8 = 1'b1; else v1 = 1'b1;
    waited = 0;
    while (((s8 ? ir8 : ir1) !== 1'b1) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", s8 ? ir8 : ir1);
    end
    acc = cyc;
    vx.push_back(x);
    vy.push_back(y);
    @(negedge clk);
    v1 = 1'b0; v8 = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; v1 = 1'b1; v8 = 1'b1;
    in_x = $urandom; in_y = $urandom; in_last = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; v1 = 1'b0; v8 = 1'b0; in_last = 1'b0;
    vectors++;
    if ({ir1, ir8} !== 2'b11) begin
      miscompares++; $display("FAIL reset_in_ready: got %b, required 11", {ir1, ir8});
    end
    vectors++;
    if ({r1, r8, l1, l8} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_ready_last: got %b, required 0000", {r1, r8, l1, l8});
    end
    vectors++;
    if ({ox1[0], ox1[1], ox1[2], ox1[3], oy1[0], oy1[1], oy1[2], oy1[3], g1} !== '0) begin
      miscompares++; $display("FAIL reset_lanes1: x0=%h y0=%h grp_idx=%0d, required all 0", ox1[0], oy1[0], g1);
    end
    vectors++;
    if ({ox8[0], ox8[1], ox8[2], ox8[3], oy8[0], oy8[1], oy8[2], oy8[3], g8} !== '0) begin
      miscompares++; $display("FAIL reset_lanes8: x0=%h y0=%h grp_idx=%0d, required all 0", ox8[0], oy8[0], g8);
    end
    idle(6);
    vectors++;
    if (cap1.size() + cap8.size() != 0) begin
      miscompares++; $display("FAIL reset_no_issue: got %0d strobes, required 0", cap1.size() + cap8.size());
    end
  endtask

  task automatic test_full_group();
    int acc, w;
    logic [W-1:0] bx[4];
    logic [W-1:0] by[4];
    bx[0] = 32'h3F800000; bx[1] = 32'h40000000; bx[2] = 32'h40400000; bx[3] = 32'h40800000;
    by[0] = 32'h40000000; by[1] = 32'h40400000; by[2] = 32'h40800000; by[3] = 32'h3F800000;
    cap1.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) send(1'b0, bx[i], by[i], i == 3, acc, w);
    model_vector();
    idle(6);
    vectors++;
    if (cap1.size() != 1) begin
      miscompares++; $display("FAIL full_count: got %0d strobes, required 1", cap1.size());
    end
    vectors++;
    if (cap1.size() > 0 && cap1[0].cyc != acc + 2) begin
      miscompares++; $display("FAIL full_latency: strobe at cycle %0d, required %0d", cap1[0].cyc, acc + 2);
    end
    for (int i = 0; i < cap1.size() && i < exp_q.size(); i++) begin
      vectors++;
      if ({cap1[i].x, cap1[i].y, cap1[i].last, cap1[i].gi} !== {exp_q[i].x, exp_q[i].y, exp_q[i].last, exp_q[i].gi}) begin
        miscompares++;
        $display("FAIL full_data g%0d: got x=%h y=%h last=%b idx=%0d, required x=%h y=%h last=%b idx=%0d", i,
                 cap1[i].x, cap1[i].y, cap1[i].last, cap1[i].gi, exp_q[i].x, exp_q[i].y, exp_q[i].last, exp_q[i].gi);
      end
    end
  endtask

  task automatic test_padding();
    int acc, w;
    cap1.delete(); exp_q.delete();
    for (int i = 0; i < 6; i++) send(1'b0, $urandom, $urandom, i == 5, acc, w);
    model_vector();
    idle(6);
    vectors++;
    if (cap1.size() != 2) begin
      miscompares++; $display("FAIL pad_count: got %0d strobes, required 2", cap1.size());
    end
    for (int i = 0; i < cap1.size() && i < exp_q.size(); i++) begin
      vectors++;
      if ({cap1[i].x, cap1[i].y, cap1[i].last, cap1[i].gi} !== {exp_q[i].x, exp_q[i].y, exp_q[i].last, exp_q[i].gi}) begin
        miscompares++;
        $display("FAIL pad_data g%0d: got x=%h y=%h last=%b idx=%0d, required x=%h y=%h last=%b idx=%0d", i,
                 cap1[i].x, cap1[i].y, cap1[i].last, cap1[i].gi, exp_q[i].x, exp_q[i].y, exp_q[i].last, exp_q[i].gi);
      end
    end
  endtask

  task automatic test_single();
    int acc, w;
    logic [4*W-1:0] ex, ey;
    cap1.delete(); exp_q.delete();
    send(1'b0, 32'h40400000, 32'h40000000, 1'b1, acc, w);
    vx.delete(); vy.delete();
    ex = {96'h0, 32'h40400000};
    ey = {96'h0, 32'h40000000};
    idle(5);
    vectors++;
    if (cap1.size() != 1) begin
      miscompares++; $display("FAIL single_count: got %0d strobes, required 1", cap1.size());
    end else begin
      vectors++;
      if ({cap1[0].x, cap1[0].y, cap1[0].last, cap1[0].gi} !== {ex, ey, 1'b1, 16'd0}) begin
        miscompares++;
        $display("FAIL single_data: got x=%h y=%h last=%b idx=%0d, required x=%h y=%h last=1 idx=0",
                 cap1[0].x, cap1[0].y, cap1[0].last, cap1[0].gi, ex, ey);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc, w, stalls, n;
    cap1.delete(); exp_q.delete();
    stalls = 0;
    for (int v = 0; v < 3; v++) begin
      n = 4 * $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        send(1'b0, $urandom, $urandom, i == n - 1, acc, w);
        if (w > 0) stalls++;
      end
      model_vector();
    end
    idle(6);
    vectors++;
    if (stalls != 0) begin
      miscompares++; $display("FAIL b2b_stall: got %0d stalled beats, required 0", stalls);
    end
    vectors++;
    if (cap1.size() != exp_q.size()) begin
      miscompares++; $display("FAIL b2b_count: got %0d strobes, required %0d", cap1.size(), exp_q.size());
    end
    for (int i = 0; i < cap1.size() && i < exp_q.size(); i++) begin
      vectors++;
      if ({cap1[i].x, cap1[i].y, cap1[i].last, cap1[i].gi} !== {exp_q[i].x, exp_q[i].y, exp_q[i].last, exp_q[i].gi}) begin
        miscompares++;
        $display("FAIL b2b_data g%0d: got x=%h y=%h last=%b idx=%0d, required x=%h y=%h last=%b idx=%0d", i,
                 cap1[i].x, cap1[i].y, cap1[i].last, cap1[i].gi, exp_q[i].x, exp_q[i].y, exp_q[i].last, exp_q[i].gi);
      end
    end
  endtask

  task automatic test_gap_throttle();
    int acc, w, stalls;
    cap8.delete(); exp_q.delete();
    stalls = 0;
    for (int i = 0; i < 12; i++) begin
      send(1'b1, $urandom, $urandom, i == 11, acc, w);
      if (w > 0) stalls++;
    end
    model_vector();
    idle(20);
    vectors++;
    if (stalls == 0) begin
      miscompares++; $display("FAIL gap_stall: got %0d stalled beats, required >0", stalls);
    end
    vectors++;
    if (cap8.size() != 3) begin
      miscompares++; $display("FAIL gap_count: got %0d strobes, required 3", cap8.size());
    end
    for (int i = 1; i < cap8.size(); i++) begin
      vectors++;
      if (cap8[i].cyc - cap8[i-1].cyc != 8) begin
        miscompares++; $display("FAIL gap_spacing g%0d: got %0d cycles, required 8", i, cap8[i].cyc - cap8[i-1].cyc);
      end
    end
    for (int i = 0; i < cap8.size() && i < exp_q.size(); i++) begin
      vectors++;
      if ({cap8[i].x, cap8[i].y, cap8[i].last, cap8[i].gi} !== {exp_q[i].x, exp_q[i].y, exp_q[i].last, exp_q[i].gi}) begin
        miscompares++;
        $display("FAIL gap_data g%0d: got x=%h y=%h last=%b idx=%0d, required x=%h y=%h last=%b idx=%0d", i,
                 cap8[i].x, cap8[i].y, cap8[i].last, cap8[i].gi, exp_q[i].x, exp_q[i].y, exp_q[i].last, exp_q[i].gi);
      end
    end
  endtask

  task automatic test_random();
    int acc, w, n;
    cap8.delete(); exp_q.delete();
    for (int v = 0; v < 6; v++) begin
      n = $urandom_range(1, 9);
      for (int i = 0; i < n; i++) begin
        send(1'b1, $urandom, $urandom, i == n - 1, acc, w);
        idle($urandom_range(0, 2));
      end
      model_vector();
    end
    idle(30);
    vectors++;
    if (cap8.size() != exp_q.size()) begin
      miscompares++; $display("FAIL rand_count: got %0d strobes, required %0d", cap8.size(), exp_q.size());
    end
    for (int i = 1; i < cap8.size(); i++) begin
      vectors++;
      if (cap8[i].cyc - cap8[i-1].cyc < 8) begin
        miscompares++; $display("FAIL rand_spacing g%0d: got %0d cycles, required >=8", i, cap8[i].cyc - cap8[i-1].cyc);
      end
    end
    for (int i = 0; i < cap8.size() && i < exp_q.size(); i++) begin
      vectors++;
      if ({cap8[i].x, cap8[i].y, cap8[i].last, cap8[i].gi} !== {exp_q[i].x, exp_q[i].y, exp_q[i].last, exp_q[i].gi}) begin
        miscompares++;
        $display("FAIL rand_data g%0d: got x=%h y=%h last=%b idx=%0d, required x=%h y=%h last=%b idx=%0d", i,
                 cap8[i].x, cap8[i].y, cap8[i].last, cap8[i].gi, exp_q[i].x, exp_q[i].y, exp_q[i].last, exp_q[i].gi);
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc, w;
    // dut1 left mid-group, dut8 left mid-gap with its group counter at 1
    for (int i = 0; i < 2; i++) send(1'b0, $urandom, $urandom, 1'b0, acc, w);
    for (int i = 0; i < 5; i++) send(1'b1, $urandom, $urandom, 1'b0, acc, w);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({r1, r8} !== 2'b00) begin
      miscompares++; $display("FAIL midrst_ready: got %b, required 00", {r1, r8});
    end
    vx.delete(); vy.delete();
    cap1.delete(); cap8.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) send(1'b0, $urandom, $urandom, i == 3, acc, w);
    model_vector();
    idle(6);
    vectors++;
    if (cap1.size() != 1) begin
      miscompares++; $display("FAIL midrst_count: got %0d strobes, required 1", cap1.size());
    end else begin
      vectors++;
      if ({cap1[0].x, cap1[0].y, cap1[0].last, cap1[0].gi} !== {exp_q[0].x, exp_q[0].y, exp_q[0].last, exp_q[0].gi}) begin
        miscompares++;
        $display("FAIL midrst_data: got x=%h y=%h last=%b idx=%0d, required x=%h y=%h last=%b idx=%0d",
                 cap1[0].x, cap1[0].y, cap1[0].last, cap1[0].gi, exp_q[0].x, exp_q[0].y, exp_q[0].last, exp_q[0].gi);
      end
    end
    // dut8: gap timer and counter cleared, so a one-beat vector issues at once with index 0
    exp_q.delete();
    send(1'b1, $urandom, $urandom, 1'b1, acc, w);
    model_vector();
    idle(4);
    vectors++;
    if (cap8.size() != 1) begin
      miscompares++; $display("FAIL midrst8_count: got %0d strobes, required 1", cap8.size());
    end else begin
      vectors++;
      if (cap8[0].cyc != acc + 2 || {cap8[0].x, cap8[0].y, cap8[0].last, cap8[0].gi} !== {exp_q[0].x, exp_q[0].y, exp_q[0].last, exp_q[0].gi}) begin
        miscompares++;
        $display("FAIL midrst8_data: got cyc=%0d x=%h last=%b idx=%0d, required cyc=%0d x=%h last=%b idx=%0d",
                 cap8[0].cyc, cap8[0].x, cap8[0].last, cap8[0].gi, acc + 2, exp_q[0].x, exp_q[0].last, exp_q[0].gi);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_group();
    test_padding();
    test_single();
    test_back_to_back();
    test_gap_throttle();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
